// File: rtl/cfg_chain_driver.sv
// Transmitter end of the configuration chain: frames host words as an ID header
// plus MSB-first payload bits, with a one-word prefetch buffer and underrun fill.
module cfg_chain_driver #(
    parameter int ID_WIDTH = 3,
    parameter int WORD_W   = 16,
    parameter int LEN_W    = 8
) (
    input  logic                clk,
    input  logic                crst_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [ID_WIDTH-1:0] cmd_id,
    input  logic [LEN_W-1:0]    cmd_len,
    input  logic                data_valid,
    output logic                data_ready,
    input  logic [WORD_W-1:0]   data,
    output logic                cfg_out_start,
    output logic                cfg_bit_out,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [2:0]          dbg_state
);

    localparam int HDR_W = $clog2(ID_WIDTH + 1);
    localparam int BIT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam int PAY_W = LEN_W + BIT_W;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        FILL = 3'd1,
        HDR  = 3'd2,
        PAY  = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t              state_q, state_n;
    logic [ID_WIDTH-1:0] hdr_sr_q, hdr_sr_n;
    logic [HDR_W-1:0]    hdr_idx_q, hdr_idx_n;
    logic [LEN_W-1:0]    len_q, len_n;
    logic [LEN_W-1:0]    fetched_q, fetched_n;
    logic [WORD_W-1:0]   sh_q, sh_n;
    logic [WORD_W-1:0]   pf_q, pf_n;
    logic                pf_full_q, pf_full_n;
    logic [BIT_W-1:0]    bit_idx_q, bit_idx_n;
    logic [PAY_W-1:0]    pay_rem_q, pay_rem_n;
    logic                underrun_q, underrun_n;
    logic                err_q, err_n;
    logic                start_n, bit_n;
    logic                pf_rdy, data_fire;

    // Both ports use plain valid/ready: a transfer happens on a rising clk edge
    // where valid and ready are both high; ready never depends on valid.
    assign cmd_ready  = crst_n && (state_q == IDLE);
    assign pf_rdy     = ((state_q == HDR) || (state_q == PAY)) && !pf_full_q &&
                        !underrun_q && (fetched_q < len_q);
    assign data_ready = crst_n && ((state_q == FILL) || pf_rdy);
    assign data_fire  = data_valid && data_ready;

    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign err       = err_q;
    assign dbg_state = state_q;

    // Wire bits are computed one cycle ahead so the registered outputs line up with the state.
    always_comb begin
        state_n    = state_q;
        hdr_sr_n   = hdr_sr_q;
        hdr_idx_n  = hdr_idx_q;
        len_n      = len_q;
        fetched_n  = fetched_q;
        sh_n       = sh_q;
        pf_n       = pf_q;
        pf_full_n  = pf_full_q;
        bit_idx_n  = bit_idx_q;
        pay_rem_n  = pay_rem_q;
        underrun_n = underrun_q;
        err_n      = err_q;
        start_n    = 1'b0;
        bit_n      = 1'b0;

        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    len_n      = cmd_len;
                    err_n      = 1'b0;
                    underrun_n = 1'b0;
                    fetched_n  = '0;
                    pf_full_n  = 1'b0;
                    hdr_idx_n  = '0;
                    bit_idx_n  = '0;
                    if (cmd_len != '0) begin
                        state_n  = FILL;
                        hdr_sr_n = cmd_id;
                    end else begin
                        state_n  = HDR;
                        start_n  = 1'b1;
                        bit_n    = cmd_id[ID_WIDTH-1];
                        hdr_sr_n = cmd_id << 1;
                    end
                end
            end
            FILL: begin
                if (data_fire) begin
                    sh_n      = data;
                    fetched_n = fetched_q + LEN_W'(1);
                    state_n   = HDR;
                    start_n   = 1'b1;
                    bit_n     = hdr_sr_q[ID_WIDTH-1];
                    hdr_sr_n  = hdr_sr_q << 1;
                end
            end
            HDR: begin
                if (data_fire) begin
                    pf_n      = data;
                    pf_full_n = 1'b1;
                    fetched_n = fetched_q + LEN_W'(1);
                end
                if (hdr_idx_q == HDR_W'(ID_WIDTH - 1)) begin
                    if (len_q != '0) begin
                        state_n   = PAY;
                        bit_n     = sh_q[WORD_W-1];
                        sh_n      = sh_q << 1;
                        bit_idx_n = '0;
                        pay_rem_n = PAY_W'(len_q) * PAY_W'(WORD_W) - PAY_W'(1);
                    end else begin
                        state_n = DONE;
                    end
                end else begin
                    hdr_idx_n = hdr_idx_q + HDR_W'(1);
                    bit_n     = hdr_sr_q[ID_WIDTH-1];
                    hdr_sr_n  = hdr_sr_q << 1;
                end
            end
            PAY: begin
                if (data_fire) begin
                    pf_n      = data;
                    pf_full_n = 1'b1;
                    fetched_n = fetched_q + LEN_W'(1);
                end
                if (pay_rem_q == '0) begin
                    state_n = DONE;
                end else begin
                    pay_rem_n = pay_rem_q - PAY_W'(1);
                    if (bit_idx_q == BIT_W'(WORD_W - 1)) begin
                        bit_idx_n = '0;
                        pf_full_n = 1'b0;
                        if (pf_full_q) begin
                            bit_n = pf_q[WORD_W-1];
                            sh_n  = pf_q << 1;
                        end else if (data_fire) begin
                            // A word arriving exactly at the boundary goes straight out.
                            bit_n = data[WORD_W-1];
                            sh_n  = data << 1;
                        end else begin
                            // Underrun: keep the frame length, zero-fill the rest.
                            underrun_n = 1'b1;
                            err_n      = 1'b1;
                            sh_n       = '0;
                        end
                    end else begin
                        bit_idx_n = bit_idx_q + BIT_W'(1);
                        bit_n     = sh_q[WORD_W-1];
                        sh_n      = sh_q << 1;
                    end
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!crst_n) begin
            state_q       <= IDLE;
            hdr_sr_q      <= '0;
            hdr_idx_q     <= '0;
            len_q         <= '0;
            fetched_q     <= '0;
            sh_q          <= '0;
            pf_q          <= '0;
            pf_full_q     <= 1'b0;
            bit_idx_q     <= '0;
            pay_rem_q     <= '0;
            underrun_q    <= 1'b0;
            err_q         <= 1'b0;
            cfg_out_start <= 1'b0;
            cfg_bit_out   <= 1'b0;
        end else begin
            state_q       <= state_n;
            hdr_sr_q      <= hdr_sr_n;
            hdr_idx_q     <= hdr_idx_n;
            len_q         <= len_n;
            fetched_q     <= fetched_n;
            sh_q          <= sh_n;
            pf_q          <= pf_n;
            pf_full_q     <= pf_full_n;
            bit_idx_q     <= bit_idx_n;
            pay_rem_q     <= pay_rem_n;
            underrun_q    <= underrun_n;
            err_q         <= err_n;
            cfg_out_start <= start_n;
            cfg_bit_out   <= bit_n;
        end
    end

endmodule
